// File: rtl/fetch_pkg.sv
// Shared opcode constants, PC width and state encoding for the fetch sequencer.
package fetch_pkg;
  localparam int unsigned PC_W = 10;

  localparam logic [2:0] OP_BR  = 3'b110;
  localparam logic [2:0] OP_CTL = 3'b111;

  localparam logic [8:0] HALT_INSN = 9'h1FF;

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_e;
endpackage

// File: rtl/fetch_sequencer_call_stack.sv
// Return-address LIFO. Push on full and pop on empty are dropped; the caller faults instead.
module call_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned SpW  = $clog2(Depth + 1);
  localparam int unsigned IdxW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [SpW-1:0]   sp_q, sp_d, sp_m1;

  assign full_o  = (sp_q == SpW'(Depth));
  assign empty_o = (sp_q == '0);
  assign sp_m1   = sp_q - SpW'(1);
  assign top_o   = mem_q[sp_m1[IdxW-1:0]];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (clr_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      mem_d[sp_q[IdxW-1:0]] = data_i;
      sp_d                  = sp_q + SpW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_m1;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    sp_q  <= sp_d;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: PC, next-PC decode, target LUT, call stack and halt/fault status.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned LUT_ENTRIES = 32,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           start,
  input  logic [8:0]                     Instruction,
  input  logic                           EQUAL,
  input  logic                           lut_we,
  input  logic [$clog2(LUT_ENTRIES)-1:0] lut_addr,
  input  logic [PC_W-1:0]                lut_data,
  output logic [PC_W-1:0]                PC,
  output logic                           halt,
  output logic                           fault
);
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  state_e          state_q, state_d;
  logic [PC_W-1:0] lut_q [LUT_ENTRIES];
  logic [PC_W-1:0] lut_d [LUT_ENTRIES];
  logic            push, pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;
  logic [2:0]      op;

  assign op     = Instruction[8:6];
  assign pc_inc = pc_q + PC_W'(1);

  // Targets survive reset; writes only land inside the start window.
  always_comb begin
    lut_d = lut_q;
    if (start && lut_we) lut_d[lut_addr] = lut_data;
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == RUN) begin
      if (Instruction == HALT_INSN) begin
        state_d = HALTED;
      end else if (op == OP_BR) begin
        pc_d = (EQUAL ^ Instruction[5]) ? lut_q[Instruction[4:0]] : pc_inc;
      end else if (op == OP_CTL) begin
        if (!Instruction[5]) begin
          pc_d = lut_q[Instruction[4:0]];
        end else if (!Instruction[4]) begin
          if (stk_full) begin
            state_d = FAULT;
          end else begin
            push = 1'b1;
            pc_d = lut_q[{1'b0, Instruction[3:0]}];
          end
        end else if (!Instruction[3]) begin
          if (stk_empty) begin
            state_d = FAULT;
          end else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end else begin
          pc_d = pc_inc;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    lut_q <= lut_d;
    if (start) begin
      pc_q    <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  call_stack #(
    .Depth (STACK_DEPTH),
    .Width (PC_W)
  ) u_call_stack (
    .clk_i   (CLK),
    .clr_i   (start),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign PC    = pc_q;
  assign halt  = (state_q != RUN);
  assign fault = (state_q == FAULT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized + directed bench: a queue/array reference model feeds a scoreboard checked at negedge.
module tb_fetch_sequencer;
  logic       CLK;
  logic       start;
  logic [8:0] Instruction;
  logic       EQUAL;
  logic       lut_we;
  logic [4:0] lut_addr;
  logic [9:0] lut_data;
  logic [9:0] PC;
  logic       halt;
  logic       fault;

  fetch_sequencer #(
    .LUT_ENTRIES (32),
    .STACK_DEPTH (4)
  ) dut (
    .CLK         (CLK),
    .start       (start),
    .Instruction (Instruction),
    .EQUAL       (EQUAL),
    .lut_we      (lut_we),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .PC          (PC),
    .halt        (halt),
    .fault       (fault)
  );

  typedef struct {
    int pc;
    bit halt;
    bit fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_pc = 0;
  bit m_halt = 0;
  bit m_fault = 0;
  int m_stack[$];
  int m_lut[32];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc", {22'b0, PC}, mon_e.pc);
      check("halt", {31'b0, halt}, {31'b0, mon_e.halt});
      check("fault", {31'b0, fault}, {31'b0, mon_e.fault});
    end
  end

  task automatic cyc(input bit st, input bit we, input int addr, input int data,
                     input logic [8:0] insn, input bit eq);
    exp_t e;
    start       = st;
    lut_we      = we;
    lut_addr    = 5'(addr);
    lut_data    = 10'(data);
    Instruction = insn;
    EQUAL       = eq;
    if (st) begin
      if (we) m_lut[addr % 32] = data % 1024;
      m_pc = 0;
      m_stack.delete();
      m_halt = 0;
      m_fault = 0;
    end else if (!m_halt) begin
      if (insn == 9'h1FF) begin
        m_halt = 1;
      end else if (insn[8:6] == 3'd6) begin
        m_pc = (eq != insn[5]) ? m_lut[insn[4:0]] : (m_pc + 1) % 1024;
      end else if (insn[8:6] == 3'd7 && insn[5] == 1'b0) begin
        m_pc = m_lut[insn[4:0]];
      end else if (insn[8:6] == 3'd7 && insn[5:4] == 2'd2) begin
        if (m_stack.size() == 4) begin
          m_halt = 1;
          m_fault = 1;
        end else begin
          m_stack.push_back((m_pc + 1) % 1024);
          m_pc = m_lut[insn[3:0]];
        end
      end else if (insn[8:6] == 3'd7 && insn[5:3] == 3'd6) begin
        if (m_stack.size() == 0) begin
          m_halt = 1;
          m_fault = 1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
    e.pc = m_pc;
    e.halt = m_halt;
    e.fault = m_fault;
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input logic [8:0] insn, input bit eq);
    cyc(1'b0, 1'b0, 0, 0, insn, eq);
  endtask

  function automatic logic [8:0] rand_insn();
    logic [8:0] r;
    case ($urandom_range(0, 9))
      0, 1, 2: r = {3'($urandom_range(0, 5)), 6'($urandom)};
      3:       r = {3'b110, 6'($urandom)};
      4:       r = {3'b111, 1'b0, 5'($urandom)};
      5, 6:    r = {3'b111, 2'b10, 4'($urandom)};
      7:       r = {3'b111, 3'b110, 3'($urandom)};
      8:       r = 9'($urandom);
      default: r = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'h000;
    endcase
    return r;
  endfunction

  initial begin
    int tgt[32];
    for (int i = 0; i < 32; i++) tgt[i] = $urandom_range(0, 1023);
    tgt[0] = 5; tgt[1] = 1022; tgt[2] = 100; tgt[3] = 40;
    tgt[4] = 10; tgt[5] = 20; tgt[31] = 700;

    // Load the whole LUT during one long start window
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, i, tgt[i], 9'h000, 1'b0);

    // Sequential fetch and wrap
    for (int i = 0; i < 5; i++) run(9'h000, 1'($urandom));
    run(9'h1C1, 1'b0);
    run(9'h000, 1'b0);
    run(9'h000, 1'b0);

    // Branches
    run(9'h1C0, 1'b0);
    run(9'h183, 1'b1);
    run(9'h1C0, 1'b0);
    run(9'h183, 1'b0);
    run(9'h1C0, 1'b0);
    run(9'h1A3, 1'b0);

    // Jump ignores EQUAL
    run(9'h1DF, 1'b1);
    run(9'h1DF, 1'b0);

    // Call / return
    run(9'h1C4, 1'b0);
    run(9'h1E2, 1'b0);
    run(9'h1F0, 1'b0);

    // Overflow fault after five nested calls, held until start
    for (int i = 0; i < 5; i++) run(9'h1E2, 1'b0);
    for (int i = 0; i < 3; i++) run(9'h000, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 9'h000, 1'b0);

    // Underflow fault
    run(9'h1F0, 1'b0);
    run(9'h000, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 9'h000, 1'b0);

    // HALT with ignored LUT writes, then verify the LUT survived
    run(9'h1C5, 1'b0);
    run(9'h1FF, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 31, $urandom_range(0, 1023), rand_insn(), 1'b0);
    cyc(1'b0, 1'b1, 31, 3, 9'h000, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 9'h000, 1'b0);
    run(9'h1DF, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        cyc(1'b1, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 1023),
            rand_insn(), 1'($urandom));
      else
        cyc(1'b0, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 1023),
            rand_insn(), 1'($urandom));
    end

    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
